// File: rtl/mem_bus_ctrl.sv
// Decodes CPU load/store requests onto NUM_SLAVES base/mask windows; one outstanding transaction,
// with a per-request watchdog, error response, fault address capture and saturating error count.
module mem_bus_ctrl #(
  parameter int                        NUM_SLAVES = 2,
  parameter logic [32*NUM_SLAVES-1:0] SLV_BASE   = {32'h1000_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0] SLV_MASK   = {32'hFFFF_F000, 32'hFFFF_0000},
  parameter int                        TIMEOUT    = 16,
  parameter logic [31:0]               ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  input  logic                       req_we,
  input  logic [2:0]                 req_mode,
  output logic                       rsp_valid,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic [NUM_SLAVES-1:0]      s_sel,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic                       s_we,
  output logic [2:0]                 s_mode,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  output logic [31:0]                fault_addr,
  output logic [7:0]                 err_count
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         sel_idx;
  logic [CW-1:0]         cnt;
  logic [31:0]           lat_addr;
  logic                  err_q;

  logic                  hit;
  logic [IW-1:0]         hit_idx;
  logic [NUM_SLAVES-1:0] hit_oh;
  logic [31:0]           hit_mask;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic                  timeout;

  // Walk from the top index down so the lowest matching window wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_oh   = '0;
    hit_mask = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((req_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit       = 1'b1;
        hit_idx   = i[IW-1:0];
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        hit_mask  = SLV_MASK[32*i +: 32];
      end
    end
  end

  assign sel_ready = s_ready[sel_idx];
  assign sel_rdata = s_rdata[32*sel_idx +: 32];
  assign timeout   = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = hit ? WAIT : RESP;
      WAIT:    if (sel_ready || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel_idx    <= '0;
      cnt        <= '0;
      lat_addr   <= '0;
      err_q      <= 1'b0;
      rsp_rdata  <= '0;
      s_sel      <= '0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_we       <= 1'b0;
      s_mode     <= '0;
      fault_addr <= '0;
      err_count  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_addr <= req_addr;
            cnt      <= '0;
            if (hit) begin
              sel_idx <= hit_idx;
              s_sel   <= hit_oh;
              s_addr  <= req_addr & ~hit_mask;
              s_wdata <= req_wdata;
              s_we    <= req_we;
              s_mode  <= req_mode;
            end else begin
              err_q      <= 1'b1;
              rsp_rdata  <= ERR_DATA;
              fault_addr <= req_addr;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A ready arriving on the last allowed cycle still counts as success.
          if (sel_ready) begin
            err_q     <= 1'b0;
            rsp_rdata <= s_we ? 32'h0 : sel_rdata;
            s_sel     <= '0;
            s_we      <= 1'b0;
          end else if (timeout) begin
            err_q      <= 1'b1;
            rsp_rdata  <= ERR_DATA;
            fault_addr <= lat_addr;
            s_sel      <= '0;
            s_we       <= 1'b0;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized scoreboard bench for mem_bus_ctrl with an address-range reference model.
module tb_mem_bus_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_mode;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  s_sel;
  logic [31:0] s_addr, s_wdata;
  logic        s_we;
  logic [2:0]  s_mode;
  logic [63:0] s_rdata;
  logic [1:0]  s_ready;
  logic [31:0] fault_addr;
  logic [7:0]  err_count;

  // Second instance with fully overlapping windows.
  logic        req_valid2, req_ready2, rsp_valid2, rsp_err2, s_we2;
  logic [31:0] req_addr2, rsp_rdata2, s_addr2, s_wdata2, fault_addr2;
  logic [1:0]  s_sel2;
  logic [2:0]  s_mode2;
  logic [7:0]  err_count2;
  logic [63:0] s_rdata2 = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
  logic [1:0]  s_ready2 = 2'b11;

  mem_bus_ctrl #(.NUM_SLAVES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_mode(s_mode),
    .s_rdata(s_rdata), .s_ready(s_ready), .fault_addr(fault_addr), .err_count(err_count));

  mem_bus_ctrl #(.NUM_SLAVES(2), .SLV_BASE({32'h0, 32'h0}),
                 .SLV_MASK({32'hFFFF_0000, 32'hFFFF_0000}), .TIMEOUT(TO)) dut_ovl (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_addr(req_addr2), .req_wdata(32'h0), .req_we(1'b0), .req_mode(3'd0),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
    .s_sel(s_sel2), .s_addr(s_addr2), .s_wdata(s_wdata2), .s_we(s_we2), .s_mode(s_mode2),
    .s_rdata(s_rdata2), .s_ready(s_ready2), .fault_addr(fault_addr2), .err_count(err_count2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    logic [31:0] fault;
    logic [7:0]  cnt;
  } exp_t;
  exp_t sbq[$];

  // Reference model state
  logic [31:0] m_fault = 0;
  logic [7:0]  m_cnt = 0;

  // Slave-side expectations for the transaction in flight
  int          cur_waits = 0;
  logic [31:0] cur_rdata = 0;
  logic [1:0]  exp_sel = 0;
  logic [31:0] exp_saddr = 0, exp_swdata = 0;
  logic        exp_swe = 0;
  logic [2:0]  exp_smode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_slave(input logic [31:0] a);
    if (a < 32'h0001_0000) return 0;
    if (a >= 32'h1000_0000 && a < 32'h1000_1000) return 1;
    return -1;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic [2:0] md, input int waits, input logic [31:0] rd,
                       input bit push);
    int g;
    int sl;
    bit err;
    exp_t e;
    g = 0;
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    sl = ref_slave(a);
    cur_waits  = waits;
    cur_rdata  = rd;
    exp_sel    = (sl < 0) ? 2'b00 : (sl == 0 ? 2'b01 : 2'b10);
    exp_saddr  = (sl == 1) ? a - 32'h1000_0000 : a;
    exp_swdata = wd;
    exp_swe    = we;
    exp_smode  = md;
    if (push) begin
      err = (sl < 0) || (waits >= TO);
      if (err) begin
        m_fault = a;
        if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
      end
      e.err   = err;
      e.rdata = err ? 32'hDEADBEEF : (we ? 32'h0 : rd);
      e.cyc   = cyc + 1 + ((sl < 0) ? 0 : (waits < TO ? 1 + waits : TO));
      e.fault = m_fault;
      e.cnt   = m_cnt;
      sbq.push_back(e);
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = wd;
    req_we    = we;
    req_mode  = md;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Slave model: checks the select/address bus and inserts wait states.
  initial begin
    int wcnt;
    int idx;
    wcnt = 0;
    s_ready = 0;
    s_rdata = 0;
    forever begin
      @(negedge clk);
      s_rdata = {$urandom, $urandom};
      s_ready = 2'($urandom);
      if (s_sel != 2'b00) begin
        idx = (exp_sel == 2'b10) ? 1 : 0;
        chk("s_sel", {30'd0, s_sel}, {30'd0, exp_sel});
        if (wcnt == 0) begin
          chk("s_addr", s_addr, exp_saddr);
          chk("s_we", {31'd0, s_we}, {31'd0, exp_swe});
          chk("s_mode", {29'd0, s_mode}, {29'd0, exp_smode});
          if (exp_swe) chk("s_wdata", s_wdata, exp_swdata);
        end
        s_ready[idx] = (wcnt == cur_waits);
        s_rdata[32*idx +: 32] = cur_rdata;
        wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rsp_valid) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: rsp_valid with nothing outstanding (cycle %0d)", cyc);
          end else begin
            e = sbq.pop_front();
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("fault_addr", fault_addr, e.fault);
            chk("err_count", {24'd0, err_count}, {24'd0, e.cnt});
          end
        end else begin
          chk("rsp_err_idle", {31'd0, rsp_err}, 32'd0);
          if (sbq.size() != 0 && cyc > sbq[0].cyc) begin
            tests++;
            fails++;
            $display("FAIL missing_rsp: no response by cycle %0d, now %0d", sbq[0].cyc, cyc);
            void'(sbq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int sel;
    int w;
    int g;
    logic [31:0] a;
    logic [31:0] edge_addr [4];
    edge_addr[0] = 32'h0000_FFFF;
    edge_addr[1] = 32'h0001_0000;
    edge_addr[2] = 32'h1000_0FFF;
    edge_addr[3] = 32'h1000_1000;

    rst = 1'b1;
    req_valid = 0; req_addr = 0; req_wdata = 0; req_we = 0; req_mode = 0;
    req_valid2 = 0; req_addr2 = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_s_sel", {30'd0, s_sel}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_fault", fault_addr, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Overlapping windows: lowest index must win.
    req_valid2 = 1'b1;
    req_addr2  = 32'h0000_0040;
    @(negedge clk);
    req_valid2 = 1'b0;
    chk("ovl_s_sel", {30'd0, s_sel2}, 32'd1);
    chk("ovl_s_addr", s_addr2, 32'h40);
    @(negedge clk);
    chk("ovl_rsp_valid", {31'd0, rsp_valid2}, 32'd1);
    chk("ovl_rsp_rdata", rsp_rdata2, 32'hAAAA_AAAA);

    // Directed cases
    issue(32'h0000_0010, 32'h0, 1'b0, 3'd2, 0, 32'h1234_5678, 1'b1);
    issue(32'h1000_0004, 32'hA5A5_A5A5, 1'b1, 3'd2, 3, 32'h0, 1'b1);
    issue(32'h2000_0000, 32'h0, 1'b0, 3'd0, 0, 32'h0, 1'b1);
    issue(32'h1000_0100, 32'h0, 1'b0, 3'd1, 99, 32'h0, 1'b1);
    issue(32'h1000_0200, 32'h0, 1'b0, 3'd4, TO - 1, 32'hCAFE_0001, 1'b1);

    // Reset during the second wait cycle abandons the transaction.
    issue(32'h1000_0008, 32'h0, 1'b0, 3'd0, 99, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_fault = 0;
    m_cnt   = 0;
    chk("rstw_s_sel", {30'd0, s_sel}, 32'd0);
    chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstw_err_count", {24'd0, err_count}, 32'd0);
    issue(32'h0000_0020, 32'h0, 1'b0, 3'd2, 1, 32'h0BAD_F00D, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      a = {16'h0, 16'($urandom)};
      else if (sel < 7) a = 32'h1000_0000 | {20'h0, 12'($urandom)};
      else if (sel < 8) a = 32'h2000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF));
      else              a = edge_addr[$urandom_range(0, 3)];
      w = $urandom_range(0, 7);
      if (w == 7) w = $urandom_range(TO - 1, TO + 2);
      issue(a, $urandom, 1'($urandom), 3'($urandom), w, $urandom, 1'b1);
    end

    // Saturate the error counter
    for (int n = 0; n < 300; n++)
      issue(32'h3000_0000 + 32'(n * 4), 32'h0, 1'b0, 3'd0, 0, 32'h0, 1'b1);

    g = 0;
    while (sbq.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_queue", sbq.size(), 32'd0);
    @(negedge clk);
    chk("err_count_sat", {24'd0, err_count}, 32'd255);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Parametrised successor to the single-RAM data-memory controller. Sits between the CPU load/store unit and NUM_SLAVES memory-mapped targets (RAM, peripherals).
- Decodes each request against per-slave base/mask windows, drives one selected slave with a region-relative offset, and waits for that slave's ready with a timeout watchdog.
- Returns data or a bus error, records the fault address, and keeps a saturating error count.
- One outstanding transaction.

Parameters:
- NUM_SLAVES, 2, number of slave windows.
- SLV_BASE, {32'h1000_0000, 32'h0000_0000}, concatenated 32-bit base per slave; slave i occupies bits [32*i+31:32*i].
- SLV_MASK, {32'hFFFF_F000, 32'hFFFF_0000}, concatenated 32-bit match mask per slave, same packing.
- TIMEOUT, 16, maximum WAIT cycles before a timeout error; must be >= 1.
- ERR_DATA, 32'hDEADBEEF, value returned on rsp_rdata for an error response.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  CPU request strobe
- req_ready  out  1  controller can accept a request
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_we  in  1  1 = write, 0 = read
- req_mode  in  3  funct3 access size/sign, passed through to slave
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  read data
- rsp_err  out  1  error flag, qualified by rsp_valid
- s_sel  out  NUM_SLAVES  one-hot slave select
- s_addr  out  32  offset = addr & ~SLV_MASK[i]
- s_wdata  out  32  latched write data
- s_we  out  1  write enable, only while s_sel != 0
- s_mode  out  3  latched mode
- s_rdata  in  32*NUM_SLAVES  packed slave read data
- s_ready  in  NUM_SLAVES  slave completion
- fault_addr  out  32  address of the most recent error
- err_count  out  8  saturating error counter

Behaviour:
- Reset: rst is synchronous and active-high.
  - Reset values: state = IDLE; req_ready = 1; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; s_sel = 0; s_we = 0; s_addr = 0; s_wdata = 0; s_mode = 0; fault_addr = 0; err_count = 0; timeout counter = 0.
  - Reset in WAIT or RESP abandons the transaction. No rsp_valid is issued and s_sel drops on the next cycle.
- Decode: slave i hits when (req_addr & SLV_MASK[i]) == SLV_BASE[i]. If several windows hit, the lowest index wins.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid at edge k, latch addr, wdata, we, mode and the selected index.
    - Hit: go to WAIT. s_sel, s_addr, s_wdata, s_we and s_mode are driven from cycle k+1.
    - Miss: go to RESP with error; no slave is strobed.
  - WAIT: req_ready = 0. s_sel stays one-hot and stable. Counter increments each cycle.
    - s_ready[sel] = 1: capture the s_rdata slice (capture 0 for writes), go to RESP with err = 0.
    - Otherwise, when counter == TIMEOUT-1: go to RESP with err = 1.
    - If s_ready and timeout coincide, s_ready wins (no error).
    - s_ready of unselected slaves is ignored.
  - RESP: rsp_valid = 1 for exactly one cycle; s_sel = 0; then return to IDLE. The CPU cannot backpressure the response.
- Error response: rsp_rdata = ERR_DATA and rsp_err = 1. fault_addr takes the request address. err_count increments, saturating at 255.
- Latency, measured from the accept edge k:
  - Hit with ready on the first WAIT cycle: rsp_valid at cycle k+2.
  - Each wait state adds 1 cycle.
  - Miss: rsp_valid at cycle k+1.
  - Timeout: rsp_valid at cycle k+1+TIMEOUT.
- Throughput: the next request can be accepted in the cycle after RESP.
- Outputs with no valid response:
  - rsp_rdata holds its last value and is meaningful only while rsp_valid = 1.
  - rsp_err = 0 whenever rsp_valid = 0.

Test Plan:
- Read 0x0000_0010, slave0 ready immediately, returning 0x1234_5678 -> s_sel = 01, s_addr = 0x10, s_we = 0; rsp_valid at k+2 with rdata 0x1234_5678, err = 0.
- Write 0x1000_0004, data 0xA5A5_A5A5, slave1 inserting 3 wait states -> s_sel = 10, s_addr = 0x004, s_we = 1 held 4 cycles; rsp_valid at k+5 with err = 0.
- Read unmapped 0x2000_0000 -> s_sel stays 0; rsp_valid at k+1 with rdata 0xDEADBEEF, err = 1; fault_addr = 0x2000_0000; err_count = 1.
- Slave1 never ready, TIMEOUT = 16 -> s_sel held for 16 cycles; rsp_valid err at k+17; s_sel drops; err_count increments.
- rst pulsed on the 2nd WAIT cycle -> next cycle IDLE, s_sel = 0, req_ready = 1, no rsp_valid; a new request then completes normally.
- 300 back-to-back unmapped reads -> err_count saturates at 255. Overlapping windows (slave1 = slave0) -> slave0 selected.
